// File: rtl/alu_slice_sequencer.sv
//------------------------------------------------------------------------------
// Module      : alu_slice_sequencer
// Description : Drives an external combinational 2-bit ALU one slice per cycle,
//               LSB first, chaining carry/borrow internally, and returns the
//               assembled WIDTH-bit result over a valid/ready port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_slice_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_a,
  output logic [1:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [1:0]       alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_err
);

  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b100;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_c;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_err;

  logic             w_legal;
  logic             w_last;
  logic [2:0]       w_sum;
  logic [2:0]       w_diff;
  logic [1:0]       w_slice;
  logic             w_c_next;
  logic [WIDTH+1:0] w_cat;

  assign w_legal = (cmd_op <= OP_XOR);
  assign w_last  = (r_idx == IDXW'(NSLICE - 1));
  // Operands are shifted right each slice, results shifted in from the top,
  // so after NSLICE slices slice 0 lands in the low bits.
  assign w_cat   = {w_slice, r_res};

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_next_state = w_legal ? ST_RUN : ST_DONE;
      ST_RUN:  if (w_last) w_next_state = ST_DONE;
      ST_DONE: if (res_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Slice result and chain bit; ALU carry is stale for logic ops and ignored
  always_comb begin
    w_sum    = {1'b0, alu_out} + {2'b00, r_c};
    w_diff   = {1'b0, alu_out} - {2'b00, r_c};
    w_slice  = alu_out;
    w_c_next = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_slice  = w_sum[1:0];
        w_c_next = alu_carry | w_sum[2];
      end
      OP_SUB: begin
        w_slice  = w_diff[1:0];
        w_c_next = alu_carry | w_diff[2];
      end
      default: ;
    endcase
  end

  // Operand capture, slice stepping and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_c     <= 1'b0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Illegal codes never reach alu_sel; the op register holds add instead
            r_op    <= w_legal ? cmd_op : OP_ADD;
            r_a     <= cmd_a;
            r_b     <= cmd_b;
            r_idx   <= '0;
            r_c     <= 1'b0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_err   <= ~w_legal;
          end
        end
        ST_RUN: begin
          r_a   <= r_a >> 2;
          r_b   <= r_b >> 2;
          r_res <= w_cat[WIDTH+1:2];
          r_c   <= w_c_next;
          r_idx <= r_idx + IDXW'(1);
          if (w_last) r_carry <= w_c_next;
        end
        default: ;
      endcase
    end
  end

  // Handshake and ALU drive outputs, decoded from state
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    alu_a     = 2'b00;
    alu_b     = 2'b00;
    alu_sel   = 3'b000;
    case (r_state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RUN: begin
        alu_a   = r_a[1:0];
        alu_b   = r_b[1:0];
        alu_sel = r_op;
      end
      ST_DONE: res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_data  = r_res;
  assign res_carry = r_carry;
  assign res_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_slice_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_slice_sequencer
// Description : Bench for alu_slice_sequencer with an attached 2-bit ALU model,
//               queue scoreboard and randomized commands.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_slice_sequencer;

  localparam int WIDTH  = 8;
  localparam int NSLICE = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = 3'b000;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic [1:0]       alu_a;
  logic [1:0]       alu_b;
  logic [2:0]       alu_sel;
  logic [1:0]       alu_out;
  logic             alu_carry;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_err;

  alu_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // 2-bit ALU slice; carry is driven high for logic ops to mimic a stale value
  always_comb begin
    alu_out   = 2'b00;
    alu_carry = 1'b1;
    case (alu_sel)
      3'b000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001: begin alu_out = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = alu_a ^ alu_b;
      default: ;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             err;
    int               acc;
    int               lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   force_low = 1'b0;
  bit   prev_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: whole-word arithmetic, no slicing
  function automatic exp_t model(input logic [2:0] op, input int a, input int b);
    exp_t e;
    int   r;
    e.carry = 1'b0;
    e.err   = 1'b0;
    e.lat   = NSLICE + 1;
    e.acc   = 0;
    r = 0;
    case (op)
      3'd0: begin r = a + b; e.carry = (r >= (1 << WIDTH)); end
      3'd1: begin r = a - b; e.carry = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    e.data = WIDTH'(r);
    return e;
  endfunction

  // Consumer ready: random unless held low by the directed backpressure test
  always @(posedge clk) begin
    #2;
    res_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every presented result against the queue head
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("alu_sel_legal", {31'd0, (alu_sel <= 3'd4)}, 32'd1);
      if (res_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("res_data", res_data, q[0].data);
          chk("res_carry", res_carry, q[0].carry);
          chk("res_err", res_err, q[0].err);
          chk("cmd_ready_in_done", cmd_ready, 1'b0);
          if (!prev_hold) chk("latency", cyc - q[0].acc, q[0].lat);
          if (res_ready) void'(q.pop_front());
        end
      end
      prev_hold = res_valid && !res_ready;
    end
  end

  // Hand a command over; returns right after the accepting edge
  task automatic start(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int k = 0; k < 50 && !cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      return;
    end
    e = model(op, int'(a), int'(b));
    e.acc = cyc;
    q.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom_range(0, 7)); cmd_a = WIDTH'($urandom); cmd_b = WIDTH'($urandom);
    ok = 1'b1;
  endtask

  // Issue a command and check the slice sequence driven to the ALU
  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit ok;
    start(op, a, b, ok);
    if (!ok) return;
    if (op > 3'd4) begin
      @(negedge clk);
      chk("illegal_alu_sel", alu_sel, 3'b000);
      chk("illegal_cmd_ready", cmd_ready, 1'b0);
    end else begin
      for (int i = 0; i < NSLICE; i++) begin
        @(negedge clk);
        chk("slice_alu_a", alu_a, (a >> (2 * i)) & 2'b11);
        chk("slice_alu_b", alu_b, (b >> (2 * i)) & 2'b11);
        chk("slice_alu_sel", alu_sel, op);
        chk("run_cmd_ready", cmd_ready, 1'b0);
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_carry"}, res_carry, 1'b0);
    chk({tag, "_res_err"}, res_err, 1'b0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
    chk({tag, "_alu_sel"}, alu_sel, 3'b000);
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Directed arithmetic and logic cases
    issue(3'b000, 8'hB7, 8'h5C);
    issue(3'b001, 8'h10, 8'h01);
    issue(3'b001, 8'h01, 8'h02);
    issue(3'b000, 8'hFF, 8'h01);
    issue(3'b010, 8'hF0, 8'h3C);
    issue(3'b011, 8'hF0, 8'h3C);
    issue(3'b100, 8'hF0, 8'h3C);
    issue(3'b110, 8'hA5, 8'h5A);
    drain();

    // Backpressure then back-to-back command
    force_low = 1'b1;
    issue(3'b000, 8'h12, 8'h34);
    for (int k = 0; k < 20 && !res_valid; k++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_res_valid", res_valid, 1'b1);
    end
    @(posedge clk); #1;
    force_low = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid && res_ready) break;
    end
    @(posedge clk); #1;
    chk("bp_release_cmd_ready", cmd_ready, 1'b1);
    issue(3'b001, 8'h40, 8'h41);
    drain();

    // Reset during slice 2 aborts the operation
    start(3'b000, 8'hFF, 8'hFF, ok);
    if (ok) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort");
    end
    issue(3'b000, 8'h01, 8'h01);
    drain();

    // Randomized commands, including illegal op codes
    for (int n = 0; n < 150; n++) begin
      issue(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/alu_slice_sequencer.md
# alu_slice_sequencer

Command-side initiator for the 2-bit ALU slice. It accepts WIDTH-bit operation requests over a valid/ready handshake and drives the external 2-bit ALU once per cycle, LSB slice first. It chains carry or borrow between slices internally, because the ALU has no carry-in. It assembles the WIDTH-bit result and returns it on a valid/ready result port. It sits between the datapath controller and a single combinational alu_2bit-style slice.

## Interface
- WIDTH, 8, operand/result width; even, ≥2; NSLICE = WIDTH/2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  sequencer can accept a request
- cmd_op  in  3  000 add, 001 sub, 010 AND, 011 OR, 100 XOR; 101–111 illegal
- cmd_a, cmd_b  in  WIDTH  operands, captured on handshake
- alu_a, alu_b  out  2  current slice operands to ALU
- alu_sel  out  3  ALU operation select
- alu_out  in  2  ALU result (combinational, same cycle)
- alu_carry  in  1  ALU carry/borrow; meaningful only for 000/001
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  assembled result
- res_carry  out  1  final carry (add) / borrow (sub); 0 for logic and illegal ops
- res_err  out  1  illegal op flag

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/a/b, clear slice index i and chain bit c.
  - Legal op → RUN. Illegal op → DONE with res_data=0, res_carry=0, res_err=1.
- RUN (one slice per cycle, i = 0..NSLICE-1):
  - alu_a = a[2i+1:2i], alu_b = b[2i+1:2i], alu_sel = op.
  - Add: {c2,s} = alu_out + c (2-bit + 1-bit, 3-bit result). Slice result = s; next c = alu_carry | c2.
  - Sub: {b2,d} = alu_out − c (3-bit). Slice result = d; next c = alu_carry | b2. alu_carry=1 means A<B in the slice.
  - Logic ops: slice result = alu_out. c is unused; alu_carry is ignored (the ALU holds it stale for logic ops).
  - Write the slice result into res_data[2i+1:2i]. At i = NSLICE-1, go to DONE with res_carry = next c (logic: 0) and res_err=0.
- DONE:
  - res_valid=1; res_data/res_carry/res_err held stable while res_ready=0.
  - On res_valid&res_ready → IDLE.
- cmd_ready=1 only in IDLE; no command overlap, no result bypass.
- Outside RUN: alu_a=0, alu_b=0, alu_sel=000. alu_sel never carries an illegal code.
- Width rules: add/sub are unsigned modulo 2^WIDTH. res_carry=1 iff a+b ≥ 2^WIDTH (add) or a<b (sub).

## Timing
- Reset values: cmd_ready=1 (IDLE), res_valid=0, res_data=0, res_carry=0, res_err=0, alu_a=0, alu_b=0, alu_sel=000, state IDLE.
- Command accepted in cycle T:
  - RUN occupies T+1..T+NSLICE.
  - res_valid first high in T+NSLICE+1.
- Illegal op accepted in T: res_valid in T+1.
- Result handshake in cycle R: cmd_ready=1 in R+1. Minimum spacing between accepts is NSLICE+2 cycles.
- Reset anywhere (mid-RUN, DONE with res_ready low) aborts the operation:
  - Next cycle all outputs at reset values.
  - No result is produced for the aborted command.
- alu_out/alu_carry sampled in the same cycle alu_a/alu_b/alu_sel are driven. Zero-latency combinational ALU required.

## Test plan
- Add, WIDTH=8, real ALU slice attached: a=0xB7, b=0x5C, op=000, accepted at T → res_valid at T+5, res_data=0x13, res_carry=1, res_err=0; alu_a sequence 3,1,3,2.
- Sub, two cases:
  - 0x10−0x01 → res_data=0x0F, res_carry=0.
  - 0x01−0x02 → res_data=0xFF, res_carry=1.
  - Borrow must propagate through all four slices.
- Logic, with a=0xF0, b=0x3C: AND → 0x30, OR → 0xFC, XOR → 0xCC; res_carry=0 every time, even after a preceding add left ALU carry high.
- Illegal op 110 accepted at T → res_valid at T+1, res_data=0x00, res_err=1, res_carry=0; alu_sel stays 000 throughout.
- Backpressure: hold res_ready=0 for 3 cycles after res_valid → outputs stable, cmd_ready=0. Release → handshake, cmd_ready=1 next cycle; a back-to-back second command is accepted and correct.
- Assert rst during RUN slice i=2 → next cycle cmd_ready=1, res_valid=0, alu outputs 0. A subsequent add 0x01+0x01 returns 0x02, carry 0.
